axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave_pkg.sv | 18 +
 rtl/axi_sram_slave_sram_1rw.sv | 37 +++
 rtl/axi_sram_slave.sv | 157 +++++++++++++++
 tb/tb_axi_sram_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI-style SRAM responder.
package axi_sram_slave_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] MEM_BASE_DEF = 64'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WCOL,
        WRSP,
        RLAT,
        RRSP
    } state_t;

endpackage

// File: rtl/axi_sram_slave_sram_1rw.sv
// Single-port 64-bit SRAM with byte write enables and registered read.
module sram_1rw
    import axi_sram_slave_pkg::*;
#(
    parameter int WORDS = 4096,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [STRB_W-1:0] be,
    input  logic [IW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Memory-side responder for the simplified AW/W/B/AR/R channel set,
// backed by an internal SRAM; one transaction at a time, writes first.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE  = MEM_BASE_DEF,
    parameter int                MEM_WORDS = 4096,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] axi_AW_ADDR,
    input  logic              axi_AW_VALID,
    output logic              axi_AW_READY,
    input  logic [DATA_W-1:0] axi_W_DATA,
    input  logic [STRB_W-1:0] axi_W_STRB,
    input  logic              axi_W_VALID,
    output logic              axi_W_READY,
    output logic              axi_B_VALID,
    input  logic              axi_B_READY,
    input  logic [ADDR_W-1:0] axi_AR_ADDR,
    input  logic              axi_AR_VALID,
    output logic              axi_AR_READY,
    output logic [DATA_W-1:0] axi_R_DATA,
    output logic              axi_R_VALID,
    input  logic              axi_R_READY,
    output logic              oob_err
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(MEM_WORDS) << 3;

    // Offsets below MEM_BASE wrap to huge values, so one compare suffices.
    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return (a - MEM_BASE) < SPAN;
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IW'((a - MEM_BASE) >> 3);
    endfunction

    state_t            state;
    logic              run_q;
    logic              aw_got, w_got;
    logic              aw_oob_q, rd_oob_q;
    logic [IW-1:0]     aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [3:0]        cnt;

    logic              idle, wcol;
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_done, w_done, commit;
    logic              wr_oob, sram_we, rd_fire;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data, sram_rdata;
    logic [STRB_W-1:0] wr_strb;

    assign idle = (state == IDLE);
    assign wcol = (state == WCOL);

    assign axi_AW_READY = run_q & (idle | (wcol & ~aw_got));
    assign axi_W_READY  = run_q & (idle | (wcol & ~w_got));
    assign axi_AR_READY = run_q & idle & ~axi_AW_VALID & ~axi_W_VALID;
    assign axi_B_VALID  = (state == WRSP);
    assign axi_R_VALID  = (state == RRSP);
    assign axi_R_DATA   = rd_oob_q ? '0 : sram_rdata;

    assign aw_hs   = axi_AW_VALID & axi_AW_READY;
    assign w_hs    = axi_W_VALID & axi_W_READY;
    assign ar_hs   = axi_AR_VALID & axi_AR_READY;
    assign aw_done = aw_got | aw_hs;
    assign w_done  = w_got | w_hs;
    assign commit  = (idle | wcol) & aw_done & w_done;

    assign wr_oob  = aw_got ? aw_oob_q : ~in_rng(axi_AW_ADDR);
    assign wr_idx  = aw_got ? aw_idx_q : idx_of(axi_AW_ADDR);
    assign wr_data = w_got ? w_data_q : axi_W_DATA;
    assign wr_strb = w_got ? w_strb_q : axi_W_STRB;
    assign sram_we = commit & ~wr_oob;
    assign rd_fire = ar_hs & in_rng(axi_AR_ADDR);

    sram_1rw #(
        .WORDS (MEM_WORDS),
        .IW    (IW)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sram_we | rd_fire),
        .we    (sram_we),
        .be    (wr_strb),
        .addr  (sram_we ? wr_idx : idx_of(axi_AR_ADDR)),
        .wdata (wr_data),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            aw_oob_q <= 1'b0;
            rd_oob_q <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            cnt      <= '0;
            oob_err  <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            oob_err <= (aw_hs & ~in_rng(axi_AW_ADDR))
                     | (ar_hs & ~in_rng(axi_AR_ADDR));
            if (aw_hs) begin
                aw_idx_q <= idx_of(axi_AW_ADDR);
                aw_oob_q <= ~in_rng(axi_AW_ADDR);
            end
            if (w_hs) begin
                w_data_q <= axi_W_DATA;
                w_strb_q <= axi_W_STRB;
            end
            unique case (state)
                IDLE, WCOL: begin
                    if (commit) begin
                        state  <= WRSP;
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                    end else if (aw_done | w_done) begin
                        state  <= WCOL;
                        aw_got <= aw_done;
                        w_got  <= w_done;
                    end else if (ar_hs) begin
                        rd_oob_q <= ~in_rng(axi_AR_ADDR);
                        cnt      <= 4'(RD_LAT);
                        state    <= (RD_LAT == 0) ? RRSP : RLAT;
                    end
                end
                WRSP: if (axi_B_READY) state <= IDLE;
                RLAT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RRSP;
                end
                RRSP: if (axi_R_READY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Master must hold VALID until its handshake.
    a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
        axi_AW_VALID && !axi_AW_READY |=> axi_AW_VALID);
    a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
        axi_W_VALID && !axi_W_READY |=> axi_W_VALID);
    a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
        axi_AR_VALID && !axi_AR_READY |=> axi_AR_VALID);

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read paths, contention,
// backpressure, out-of-range accesses and reset mid-read.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] aw_addr, w_data, ar_addr, r_data;
    logic [7:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic        b_valid, b_ready, ar_valid, ar_ready;
    logic        r_valid, r_ready, oob;

    int n_total = 0;
    int n_bad   = 0;

    axi_sram_slave #(
        .MEM_BASE  (64'h8000_0000),
        .MEM_WORDS (4096),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi_AW_ADDR  (aw_addr),
        .axi_AW_VALID (aw_valid),
        .axi_AW_READY (aw_ready),
        .axi_W_DATA   (w_data),
        .axi_W_STRB   (w_strb),
        .axi_W_VALID  (w_valid),
        .axi_W_READY  (w_ready),
        .axi_B_VALID  (b_valid),
        .axi_B_READY  (b_ready),
        .axi_AR_ADDR  (ar_addr),
        .axi_AR_VALID (ar_valid),
        .axi_AR_READY (ar_ready),
        .axi_R_DATA   (r_data),
        .axi_R_VALID  (r_valid),
        .axi_R_READY  (r_ready),
        .oob_err      (oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW and W in the same cycle; B_VALID must appear the next cycle.
    task automatic wr(input string tag, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] s);
        aw_addr = a; w_data = d; w_strb = s;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        #1;
        chk({tag, "_awrdy"}, 64'(aw_ready & w_ready), 64'd1);
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk({tag, "_bval"}, 64'(b_valid), 64'd1);
        step();
        chk({tag, "_bdone"}, 64'(b_valid), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [63:0] a,
                      input logic [63:0] exp);
        int lat;
        int w;
        ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
        #1;
        w = 0;
        while (!ar_ready && w < 20) begin
            step(); w++;
        end
        chk({tag, "_arwait"}, 64'(ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            step(); lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_data"}, r_data, exp);
        step();
        chk({tag, "_rdone"}, 64'(r_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        b_ready = 1'b0; r_ready = 1'b0;
        #13;
        chk("rst_ready",
            64'({aw_ready, w_ready, ar_ready}), 64'd0);
        chk("rst_valid", 64'({b_valid, r_valid, oob}), 64'd0);
        chk("rst_rdata", r_data, 64'd0);
        #10 rst_n = 1'b1;
        step(); step();
        chk("idle_awrdy", 64'(aw_ready), 64'd1);

        // basic write then read
        wr("w1", 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
        rd("r1", 64'h8000_0010, 64'h1122_3344_5566_7788);

        // W three cycles ahead of AW, partial strobe
        w_data = 64'hFFFF_FFFF_AAAA_BBBB; w_strb = 8'h0F;
        w_valid = 1'b1; b_ready = 1'b1;
        #1;
        chk("wfirst_wrdy", 64'(w_ready), 64'd1);
        step();
        w_valid = 1'b0;
        #1;
        chk("wcol_rdy", 64'({aw_ready, w_ready, ar_ready}), 64'b100);
        step(); step();
        aw_addr = 64'h8000_0010; aw_valid = 1'b1;
        #1;
        chk("wcol_awrdy", 64'(aw_ready), 64'd1);
        step();
        aw_valid = 1'b0;
        chk("wcol_bval", 64'(b_valid), 64'd1);
        step();
        rd("r2", 64'h8000_0010, 64'h1122_3344_AAAA_BBBB);

        // AR/AW/W contention with B backpressure
        ar_addr = 64'h8000_0018; ar_valid = 1'b1;
        aw_addr = 64'h8000_0018; aw_valid = 1'b1;
        w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF; w_valid = 1'b1;
        b_ready = 1'b0; r_ready = 1'b0;
        #1;
        chk("cont_arrdy", 64'(ar_ready), 64'd0);
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bhold",
                64'({b_valid, aw_ready, w_ready, ar_ready}), 64'b1000);
            step();
        end
        b_ready = 1'b1;
        step();
        chk("cont_ar_after_b", 64'({b_valid, ar_ready}), 64'b01);
        step();
        ar_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rhold_val", 64'(r_valid), 64'd1);
            chk("rhold_data", r_data, 64'h0123_4567_89AB_CDEF);
            chk("rhold_rdy", 64'({aw_ready, w_ready, ar_ready}), 64'd0);
            step();
        end
        r_ready = 1'b1;
        step();
        chk("rkeep", {63'd0, r_valid} ^ r_data, 64'h0123_4567_89AB_CDEF);

        // zero strobe: no change
        wr("wz", 64'h8000_0018, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        rd("rz", 64'h8000_0018, 64'h0123_4567_89AB_CDEF);

        // boundary words
        wr("wlo", 64'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
        wr("whi", 64'h8000_7FF8, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF);
        rd("rhi", 64'h8000_7FF8, 64'h0F0F_0F0F_F0F0_F0F0);

        // out-of-range read
        ar_addr = 64'h7FFF_FFF8; ar_valid = 1'b1; r_ready = 1'b1;
        #1;
        chk("oobr_arrdy", 64'(ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
        chk("oobr_pulse", 64'(oob), 64'd1);
        step();
        chk("oobr_resp", 64'({oob, r_valid}), 64'b01);
        chk("oobr_data", r_data, 64'd0);
        step();

        // out-of-range write: B returned, oob pulse, array untouched
        aw_addr = 64'h8000_8000; aw_valid = 1'b1;
        w_data = 64'hFFFF_FFFF_FFFF_FFFF; w_strb = 8'hFF; w_valid = 1'b1;
        b_ready = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("oobw_resp", 64'({oob, b_valid}), 64'b11);
        step();
        chk("oobw_pulse", 64'(oob), 64'd0);
        rd("rlo", 64'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A);

        // reset while in RLAT
        ar_addr = 64'h8000_0010; ar_valid = 1'b1; r_ready = 1'b1;
        #1;
        chk("rstr_arrdy", 64'(ar_ready), 64'd1);
        step();
        ar_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstr_outs",
            64'({aw_ready, w_ready, ar_ready, b_valid, r_valid}), 64'd0);
        chk("rstr_rdata", r_data, 64'd0);
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rstr_noR", 64'(r_valid), 64'd0);
            step();
        end
        rd("rpost", 64'h8000_0010, 64'h1122_3344_AAAA_BBBB);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
